// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: access-length codes, FSM states
// and lane helpers for byte enables, store replication and alignment.
package mem_pkg;

    typedef enum logic [2:0] {
        LEN_W  = 3'd0,
        LEN_H  = 3'd1,
        LEN_HU = 3'd2,
        LEN_B  = 3'd3,
        LEN_BU = 3'd4
    } len_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Unknown length codes fall back to a full word access.
    function automatic len_e norm_len(input logic [7:0] code);
        case (code)
            8'd1:    return LEN_H;
            8'd2:    return LEN_HU;
            8'd3:    return LEN_B;
            8'd4:    return LEN_BU;
            default: return LEN_W;
        endcase
    endfunction

    function automatic logic [3:0] lane_byteen(input len_e len, input logic [1:0] lo);
        case (len)
            LEN_H, LEN_HU: return 4'b0011 << {lo[1], 1'b0};
            LEN_B, LEN_BU: return 4'b0001 << lo;
            default:       return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input len_e len, input logic [31:0] d);
        case (len)
            LEN_H, LEN_HU: return {2{d[15:0]}};
            LEN_B, LEN_BU: return {4{d[7:0]}};
            default:       return d;
        endcase
    endfunction

    function automatic logic misaligned(input len_e len, input logic [1:0] lo);
        case (len)
            LEN_W:         return lo != 2'b00;
            LEN_H, LEN_HU: return lo[0];
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-lane extractor: selects the addressed half/byte of a bus word and
// sign- or zero-extends it to 32 bits.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lo,
    input  len_e        i_len,
    output logic [31:0] o_ext
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        case (i_len)
            LEN_H:   o_ext = {{16{w_half[15]}}, w_half};
            LEN_HU:  o_ext = {16'h0000, w_half};
            LEN_B:   o_ext = {{24{w_byte[7]}}, w_byte};
            LEN_BU:  o_ext = {24'h000000, w_byte};
            default: o_ext = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory bus master with req/ready handshake, pipeline stall and timeout.
// Define MISALIGN_TRAP_EN to trap misaligned W/H accesses instead of ignoring low address bits.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_regRD2,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemRead,
    input  logic [7:0]  MEM_MemLen,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_byteen,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic        misalign_exc
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_e      r_state, w_next;
    logic [29:0] r_addr;
    logic [1:0]  r_lo;
    len_e        r_len;
    logic        r_we, r_rd, r_err;
    logic [3:0]  r_byteen;
    logic [31:0] r_wdata, r_pc, r_load;
    logic [7:0]  r_cnt;
    logic        w_access, w_read, w_mis, w_timeout;
    len_e        w_len;
    logic [31:0] w_ext;

    assign w_access  = MEM_MemRead | MEM_MemWrite;
    assign w_read    = MEM_MemRead & ~MEM_MemWrite;
    assign w_len     = norm_len(MEM_MemLen);
    assign w_timeout = (r_cnt == TO_CNT) && !dm_ready;

`ifdef MISALIGN_TRAP_EN
    logic r_mis;
    assign w_mis = misaligned(w_len, MEM_ALUOut[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    mem_load_ext u_ext (
        .i_rdata (dm_rdata),
        .i_lo    (r_lo),
        .i_len   (r_len),
        .o_ext   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_access) w_next = w_mis ? S_DONE : S_REQ;
            S_REQ:   if (dm_ready || w_timeout) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dm_req     = (r_state == S_REQ);
        mem_stall  = (r_state == S_REQ) || ((r_state == S_IDLE) && w_access);
        load_valid = (r_state == S_DONE) && r_rd;
        bus_err    = (r_state == S_DONE) && r_err;
`ifdef MISALIGN_TRAP_EN
        misalign_exc = (r_state == S_DONE) && r_mis;
`else
        misalign_exc = 1'b0;
`endif
    end

    // Transaction latch in IDLE; completion/timeout capture in REQ.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr   <= '0;
            r_lo     <= '0;
            r_len    <= LEN_W;
            r_we     <= 1'b0;
            r_rd     <= 1'b0;
            r_err    <= 1'b0;
            r_byteen <= '0;
            r_wdata  <= '0;
            r_pc     <= 32'h0000_3000;
            r_load   <= '0;
            r_cnt    <= '0;
`ifdef MISALIGN_TRAP_EN
            r_mis    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr   <= MEM_ALUOut[31:2];
                        r_lo     <= MEM_ALUOut[1:0];
                        r_len    <= w_len;
                        r_we     <= MEM_MemWrite;
                        r_rd     <= w_read;
                        r_err    <= 1'b0;
                        r_byteen <= lane_byteen(w_len, MEM_ALUOut[1:0]);
                        r_wdata  <= lane_wdata(w_len, MEM_regRD2);
                        r_pc     <= MEM_pc;
                        r_cnt    <= 8'd1;
`ifdef MISALIGN_TRAP_EN
                        r_mis    <= w_mis;
                        if (w_mis) r_load <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (dm_ready) begin
                        if (r_rd) r_load <= w_ext;
                    end else if (w_timeout) begin
                        r_err  <= 1'b1;
                        r_load <= ERR_DATA;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign dm_we     = r_we;
    assign dm_addr   = {r_addr, 2'b00};
    assign dm_byteen = r_byteen;
    assign dm_wdata  = r_wdata;
    assign dm_pc     = r_pc;
    assign load_data = r_load;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of access vectors plus reset and timeout sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MEM_pc, MEM_ALUOut, MEM_regRD2;
    logic        MEM_MemWrite, MEM_MemRead;
    logic [7:0]  MEM_MemLen;
    logic        dm_req, dm_we, dm_ready;
    logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
    logic [3:0]  dm_byteen;
    logic        mem_stall, load_valid, bus_err, misalign_exc;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .MEM_pc       (MEM_pc),
        .MEM_ALUOut   (MEM_ALUOut),
        .MEM_regRD2   (MEM_regRD2),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemLen   (MEM_MemLen),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_byteen    (dm_byteen),
        .dm_wdata     (dm_wdata),
        .dm_pc        (dm_pc),
        .dm_ready     (dm_ready),
        .dm_rdata     (dm_rdata),
        .mem_stall    (mem_stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .bus_err      (bus_err),
        .misalign_exc (misalign_exc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        we;
        logic        rd;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;   // REQ cycle in which ready is given; 0 = never
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        logic        e_lv;
        logic        e_err;
        logic        e_mis;
        int          e_req;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len, input logic we,
                                input logic rd, input logic [31:0] wd, input logic [31:0] rdata,
                                input int delay, input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_ld, input logic e_lv,
                                input logic e_err, input logic e_mis, input int e_req);
        vec_t v;
        v.addr = addr; v.len = len; v.we = we; v.rd = rd; v.wd = wd; v.rdata = rdata;
        v.delay = delay; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_ld = e_ld;
        v.e_lv = e_lv; v.e_err = e_err; v.e_mis = e_mis; v.e_req = e_req;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        MEM_ALUOut   = '0;
        MEM_regRD2   = '0;
        MEM_MemLen   = '0;
        dm_ready     = 1'b0;
        dm_rdata     = '0;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input logic [31:0] pc);
        int n;
        int stalls;
        bit done;
        step();
        MEM_pc = pc; MEM_ALUOut = v.addr; MEM_regRD2 = v.wd; MEM_MemLen = v.len;
        MEM_MemWrite = v.we; MEM_MemRead = v.rd;
        #1;
        n = 0; stalls = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (dm_req) begin
                n++;
                if (n == 1) begin
                    chk({tag, " dm_addr"}, dm_addr, v.e_addr);
                    chk({tag, " dm_byteen"}, {28'h0, dm_byteen}, {28'h0, v.e_be});
                    chk({tag, " dm_we"}, {31'h0, dm_we}, {31'h0, v.we});
                    chk({tag, " dm_pc"}, dm_pc, pc);
                    if (v.we) chk({tag, " dm_wdata"}, dm_wdata, v.e_wdata);
                end
                dm_ready = (n == v.delay);
                dm_rdata = v.rdata;
            end else if (c > 0) begin
                done = 1;
                chk({tag, " load_valid"}, {31'h0, load_valid}, {31'h0, v.e_lv});
                chk({tag, " bus_err"}, {31'h0, bus_err}, {31'h0, v.e_err});
                chk({tag, " misalign_exc"}, {31'h0, misalign_exc}, {31'h0, v.e_mis});
                if (v.rd && !v.we) chk({tag, " load_data"}, load_data, v.e_ld);
                chk({tag, " req_cycles"}, n, v.e_req);
                chk({tag, " stall_cycles"}, stalls, v.e_req + 1);
            end
            if (mem_stall) stalls++;
            if (!done) step();
        end
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no completion within 400 cycles", tag);
        end
        clear_inputs();
    endtask

    initial begin
        vecs[0]  = mk(32'h10, 8'd0, 0, 1, 32'h0, 32'h1234_5678, 2,
                      32'h10, 4'b1111, 32'h0, 32'h1234_5678, 1, 0, 0, 2);
        vecs[1]  = mk(32'h13, 8'd3, 0, 1, 32'h0, 32'h80FF_FFFF, 1,
                      32'h10, 4'b1000, 32'h0, 32'hFFFF_FF80, 1, 0, 0, 1);
        vecs[2]  = mk(32'h13, 8'd4, 0, 1, 32'h0, 32'h80FF_FFFF, 1,
                      32'h10, 4'b1000, 32'h0, 32'h0000_0080, 1, 0, 0, 1);
        vecs[3]  = mk(32'h22, 8'd1, 1, 0, 32'h0000_ABCD, 32'h0, 1,
                      32'h20, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0, 0, 1);
        vecs[4]  = mk(32'h22, 8'd1, 0, 1, 32'h0, 32'h8001_7FFF, 3,
                      32'h20, 4'b1100, 32'h0, 32'hFFFF_8001, 1, 0, 0, 3);
        vecs[5]  = mk(32'h20, 8'd2, 0, 1, 32'h0, 32'h8001_F00F, 1,
                      32'h20, 4'b0011, 32'h0, 32'h0000_F00F, 1, 0, 0, 1);
        vecs[6]  = mk(32'h11, 8'd3, 1, 0, 32'h1234_5678, 32'h0, 1,
                      32'h10, 4'b0010, 32'h7878_7878, 32'h0, 0, 0, 0, 1);
        vecs[7]  = mk(32'h1C, 8'd0, 1, 0, 32'hCAFE_F00D, 32'h0, 2,
                      32'h1C, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 2);
        vecs[8]  = mk(32'h11, 8'd3, 0, 1, 32'h0, 32'h1234_5678, 1,
                      32'h10, 4'b0010, 32'h0, 32'h0000_0056, 1, 0, 0, 1);
        vecs[9]  = mk(32'h04, 8'd7, 0, 1, 32'h0, 32'hA5A5_A5A5, 1,
                      32'h04, 4'b1111, 32'h0, 32'hA5A5_A5A5, 1, 0, 0, 1);
        vecs[10] = mk(32'h08, 8'd0, 1, 1, 32'h1122_3344, 32'h5555_5555, 1,
                      32'h08, 4'b1111, 32'h1122_3344, 32'h0, 0, 0, 0, 1);
`ifdef MISALIGN_TRAP_EN
        vecs[11] = mk(32'h12, 8'd0, 0, 1, 32'h0, 32'h0BAD_F00D, 1,
                      32'h10, 4'b1111, 32'h0, 32'h0, 1, 0, 1, 0);
`else
        vecs[11] = mk(32'h12, 8'd0, 0, 1, 32'h0, 32'h0BAD_F00D, 1,
                      32'h10, 4'b1111, 32'h0, 32'h0BAD_F00D, 1, 0, 0, 1);
`endif
        vecs[12] = mk(32'h40, 8'd0, 0, 1, 32'h0, 32'h0, 0,
                      32'h40, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1, 1, 0, 255);

        reset = 1'b0;
        MEM_pc = '0;
        clear_inputs();
        repeat (3) step();
        chk("rst dm_req", {31'h0, dm_req}, 32'h0);
        chk("rst mem_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst dm_pc", dm_pc, 32'h0000_3000);
        chk("rst dm_byteen", {28'h0, dm_byteen}, 32'h0);
        chk("rst load_data", load_data, 32'h0);
        chk("rst load_valid", {31'h0, load_valid}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("vec%0d", i), vecs[i], 32'h400 + 32'(i) * 4);

        // Reset asserted during the second REQ cycle of a load.
        step();
        MEM_pc = 32'h800; MEM_ALUOut = 32'h30; MEM_MemLen = 8'd0; MEM_MemRead = 1'b1;
        step();
        chk("midrst req1", {31'h0, dm_req}, 32'h1);
        step();
        chk("midrst req2", {31'h0, dm_req}, 32'h1);
        reset = 1'b0;
        MEM_MemRead = 1'b0;
        step();
        chk("midrst dm_req", {31'h0, dm_req}, 32'h0);
        chk("midrst mem_stall", {31'h0, mem_stall}, 32'h0);
        chk("midrst dm_pc", dm_pc, 32'h0000_3000);
        chk("midrst dm_addr", dm_addr, 32'h0);
        chk("midrst dm_we", {31'h0, dm_we}, 32'h0);
        chk("midrst load_data", load_data, 32'h0);
        chk("midrst load_valid", {31'h0, load_valid}, 32'h0);
        chk("midrst bus_err", {31'h0, bus_err}, 32'h0);
        reset = 1'b1;
        step();
        chk("postrst idle", {31'h0, dm_req}, 32'h0);

        run_vec("postrst", mk(32'h32, 8'd4, 0, 1, 32'h0, 32'h00FE_0000, 1,
                              32'h30, 4'b0100, 32'h0, 32'h0000_00FE, 1, 0, 0, 1), 32'h804);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
